stump_seq_alu: RTL
==================

Name: stump_seq_alu

Overview:
Parametrised, registered successor to the combinational Stump ALU. Supports configurable datapath width and adds an iterative shift-add multiply. Has a start/done handshake, an internal registered flags word with write-enable, and registered outputs. Sits between the register-file read ports and the writeback/flags logic of the multi-cycle Stump datapath.

Parameters:
WIDTH, 16, datapath width in bits (legal range 4..32)
CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived; do not override)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  operation request; accepted when ready=1
func  input  3  000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 MUL, 111 ADDR
operand_A  input  WIDTH  first operand
operand_B  input  WIDTH  second operand
c_in  input  1  carry/borrow input for ADC/SBC
csh  input  1  shifter carry, becomes C for AND/OR
flags_we  input  1  update flag register on completion
ready  output  1  1 when a start will be accepted
busy  output  1  1 while a MUL is iterating
done  output  1  one-cycle pulse: result/flags valid
result  output  WIDTH  registered result, held until next completion
flags_out  output  4  registered {N,Z,V,C}

Behaviour:
- FSM states: IDLE, MULT, DONE. Reset sends the FSM to IDLE and sets result=0, flags_out=0, done=0, busy=0, ready=1.
- A reset asserted mid-MULT aborts the multiply. The partial product is discarded and flags are not updated.
- ready = (state != MULT). busy = (state == MULT). done = (state == DONE).
- Accept: on an edge with start=1 and ready=1, latch func, operands, c_in, csh and flags_we. start with ready=0 is ignored and has no side effects.
- Single-cycle ops (func != 110):
  - Result and flags are computed and registered at the accept edge. The FSM goes to DONE.
  - done is high in the cycle immediately after start, i.e. latency 1.
- Back-to-back: start is accepted in DONE. The FSM re-enters DONE or MULT. done stays high for consecutive completions.
- In DONE with no start, the FSM returns to IDLE. result and flags_out hold.
- MUL sequence:
  - At the accept edge, load acc(2*WIDTH)=0, mcand=zero-extended A, mplier=B, count=WIDTH. FSM goes to MULT.
  - Each MULT edge: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, count-=1.
  - The edge where count goes 1->0 writes result=acc[WIDTH-1:0] (including the final add) and enters DONE.
  - done is high exactly WIDTH+1 cycles after the start cycle. busy is high for WIDTH cycles.
- Arithmetic is computed at WIDTH+1 bits; C = bit WIDTH.
  - ADD: A+B.
  - ADC: A+B+c_in.
  - SUB: A+~B+1.
  - SBC: A+~B+~c_in (A-B-c_in; c_in is a borrow).
  - C=1 means no borrow for SUB/SBC.
- N = result[WIDTH-1]. Z = (result==0).
- V:
  - ADD/ADC: A and B signs equal and result sign differs.
  - SUB/SBC: A and B signs differ and result sign differs from A.
- AND/OR: V=0, C=latched csh.
- MUL: N and Z from the low half. V = (acc[2*WIDTH-1:WIDTH] != 0), meaning the product was truncated. C=0.
- ADDR: result=A+B (truncated). flags_out is never written, regardless of flags_we.
- flags_out updates on the completing edge only if latched flags_we=1 and func != ADDR. Otherwise it holds.
- Operand or func changes after acceptance have no effect on the in-flight operation.

Test Plan:
- ADD 0x7FFF+0x0001, flags_we=1 -> next cycle done=1, result=0x8000, flags_out=1010.
- SUB 0x0005-0x0005, then SBC 0x0005-0x0003 with c_in=1, issued back-to-back -> done on two consecutive cycles; results 0x0000 (flags 0101) then 0x0001 (flags 0001).
- MUL 0x0100*0x0100 -> busy for 16 cycles, done exactly 17 cycles after start, result=0x0000, flags_out=0110. A start issued at cycle 5 is ignored.
- MUL 0x0003*0x0005 followed by ADDR 0x1000+0x0234 with flags_we=1 -> result 0x000F (flags 0000), then 0x1234 with flags_out still 0000.
- Assert rst at MULT cycle 8 -> next cycle state IDLE, result=0, flags=0, done never pulses. A new ADD 0x0001+0x0001 completes normally with result 0x0002.
- WIDTH=8 instance: AND 0xF0&0x0F with csh=1 -> result 0x00, flags 0101. ADD 0xFF+0x01 -> result 0x00, flags 0101. MUL 0x10*0x10 -> done after 9 cycles, V=1.

Source files
------------

// File: rtl/stump_seq_alu.sv
// ---------------------------------------------------------------------------
// stump_seq_alu
// Registered, parametrised Stump ALU with an iterative shift-add multiplier.
// Single-cycle operations complete on the edge that accepts them. MUL runs
// WIDTH iterations before it completes. Result and flags are registered and
// hold their value until the next completion.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset
//   start      operation request, accepted when ready=1
//   func       000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR,
//              110 MUL, 111 ADDR
//   operand_A  first operand
//   operand_B  second operand
//   c_in       carry (ADC) or borrow (SBC) input
//   csh        shifter carry, becomes C for AND/OR
//   flags_we   update the flag register when the operation completes
//   ready      a start will be accepted this cycle
//   busy       a multiply is iterating
//   done       one-cycle pulse: result/flags_out were just updated
//   result     registered result
//   flags_out  registered {N,Z,V,C}
// ---------------------------------------------------------------------------
module stump_seq_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic             c_in,
    input  logic             csh,
    input  logic             flags_we,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out
);

    localparam logic [2:0] F_ADD  = 3'b000;
    localparam logic [2:0] F_ADC  = 3'b001;
    localparam logic [2:0] F_SUB  = 3'b010;
    localparam logic [2:0] F_SBC  = 3'b011;
    localparam logic [2:0] F_AND  = 3'b100;
    localparam logic [2:0] F_OR   = 3'b101;
    localparam logic [2:0] F_MUL  = 3'b110;
    localparam logic [2:0] F_ADDR = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;

    state_t state, state_nxt;

    // Iterative multiplier state; no reset needed, it is reloaded on accept.
    logic [2*WIDTH-1:0] acc_p0, mcand_p0, acc_nxt;
    logic [WIDTH-1:0]   mplier_p0;
    logic [CNT_W-1:0]   count_p0;
    logic               fwe_p0;

    logic               accept;
    logic               mul_last;
    logic [WIDTH+3:0]   eval;
    logic [3:0]         mul_flags;

    // Single-cycle evaluation: returns {result, N, Z, V, C}.
    function automatic logic [WIDTH+3:0] alu_eval(
        input logic [2:0]       f,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             ci,
        input logic             cs
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] r;
        logic             v;
        logic             c;
        sum = '0;
        r   = '0;
        v   = 1'b0;
        c   = 1'b0;
        case (f)
            F_ADD, F_ADC: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (f == F_ADC) & ci};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            F_SUB, F_SBC: begin
                // SUB adds 1, SBC adds ~c_in: c_in acts as a borrow.
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, (f == F_SUB) | ~ci};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            F_AND: begin
                r = a & b;
                c = cs;
            end
            F_OR: begin
                r = a | b;
                c = cs;
            end
            F_ADDR: r = a + b;
            default: r = '0;
        endcase
        return {r, r[WIDTH-1], (r == '0), v, c};
    endfunction

    assign accept   = start && ready;
    assign mul_last = (state == S_MULT) && (count_p0 == CNT_W'(1));
    assign eval     = alu_eval(func, operand_A, operand_B, c_in, csh);
    assign acc_nxt  = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
    // V flags a product that did not fit in WIDTH bits.
    assign mul_flags = {acc_nxt[WIDTH-1], (acc_nxt[WIDTH-1:0] == '0),
                        (acc_nxt[2*WIDTH-1:WIDTH] != '0), 1'b0};

    // ---- FSM state register ----
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) state_nxt = (func == F_MUL) ? S_MULT : S_DONE;
                else        state_nxt = S_IDLE;
            end
            S_MULT: if (mul_last) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state != S_MULT);
        busy  = (state == S_MULT);
        done  = (state == S_DONE);
    end

    // ---- Multiplier iteration (loaded on accept, stepped in MULT) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            fwe_p0    <= flags_we;
            acc_p0    <= '0;
            mcand_p0  <= {{WIDTH{1'b0}}, operand_A};
            mplier_p0 <= operand_B;
            count_p0  <= CNT_W'(WIDTH);
        end else if (state == S_MULT) begin
            acc_p0    <= acc_nxt;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
            count_p0  <= count_p0 - CNT_W'(1);
        end
    end

    // ---- Completion registers: result and flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            flags_out <= '0;
        end else if (accept && (func != F_MUL)) begin
            result <= eval[WIDTH+3:4];
            if (flags_we && (func != F_ADDR)) flags_out <= eval[3:0];
        end else if (mul_last) begin
            result <= acc_nxt[WIDTH-1:0];
            if (fwe_p0) flags_out <= mul_flags;
        end
    end

endmodule
